// File: rtl/sa_div_pkg.sv
// sa_div_pkg: shared definitions for the sequential restoring divider.
//   state_t    : controller states (IDLE, CALC, DONE)
//   MAX_W      : widest operand the helper function handles
//   DIV0_Q     : quotient reported on divide-by-zero (all ones; cast to WIDTH)
//   abs_mag()  : magnitude of a w-bit two's complement value (signed build)
package sa_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    localparam logic [MAX_W-1:0] DIV0_Q = '1;

    // v holds a w-bit two's complement value zero-extended to MAX_W bits.
    // The result is its unsigned magnitude in the low w bits, so the most
    // negative value maps to 2^(w-1), which is still representable.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] mask;
        logic             neg;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        neg  = |(v & (MAX_W'(1) << (w - 1)));
        if (neg) begin
            return (~v + MAX_W'(1)) & mask;
        end
        return v & mask;
    endfunction

endpackage

// File: rtl/sa_div_step.sv
// sa_div_step: one combinational restoring-division iteration.
//   prem      in  WIDTH+1  current partial remainder (always < divisor)
//   bit_in    in  1        next dividend bit shifted into the remainder
//   divisor   in  WIDTH    divisor magnitude
//   prem_next out WIDTH+1  partial remainder after the trial subtraction
//   q_bit     out 1        quotient bit produced by this iteration
module sa_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   prem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One extra bit above the shifted remainder keeps the sign of the
    // trial subtraction; a set sign bit means the divisor did not fit.
    assign shifted   = {prem, bit_in};
    assign trial     = shifted - {2'b00, divisor};
    assign q_bit     = ~trial[WIDTH+1];
    assign prem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/sa_seq_divider.sv
// sa_seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Optional feature macro: SA_DIV_SIGNED_EN (two's complement operands,
// truncating division on magnitudes with sign correction of the results).
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   request, accepted only in IDLE or DONE
//   dividend     in   WIDTH  captured on accepted start
//   divisor      in   WIDTH  captured on accepted start
//   busy         out  high while iterating (CALC)
//   done         out  high for the single cycle spent in DONE
//   quotient     out  WIDTH  registered, held until next completion
//   remainder    out  WIDTH  registered, held until next completion
//   div_by_zero  out  set together with done when the divisor was zero
// Handshake: start is sampled on a rising edge only while the unit is ready
// (IDLE or DONE); the operands are consumed on that same edge, start seen
// during CALC is ignored, and results are valid exactly while done is high.
module sa_seq_divider
    import sa_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   prem;
    // dvd feeds dividend bits out of its MSB and collects quotient bits at
    // its LSB, so after WIDTH iterations it holds the quotient magnitude.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   step_prem;
    logic             step_q;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == CALC) && (cnt == CNT_W'(1));
    assign busy   = (state == CALC);
    assign done   = (state == DONE);

    sa_div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .bit_in    (dvd[WIDTH-1]),
        .divisor   (dvs),
        .prem_next (step_prem),
        .q_bit     (step_q)
    );

    assign q_mag = {dvd[WIDTH-2:0], step_q};
    assign r_mag = step_prem[WIDTH-1:0];

`ifdef SA_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    // Quotient magnitude 2^(WIDTH-1) with neg_q clear (-min / -1) wraps to
    // the most negative value without any special casing.
    assign q_res = neg_q ? (~q_mag + WIDTH'(1)) : q_mag;
    assign r_res = neg_r ? (~r_mag + WIDTH'(1)) : r_mag;
`else
    assign q_res = q_mag;
    assign r_res = r_mag;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            prem        <= '0;
            dvd         <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SA_DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= WIDTH'(DIV0_Q);
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
                prem        <= '0;
                cnt         <= CNT_W'(WIDTH);
`ifdef SA_DIV_SIGNED_EN
                dvd   <= WIDTH'(abs_mag(MAX_W'(dividend), WIDTH));
                dvs   <= WIDTH'(abs_mag(MAX_W'(divisor), WIDTH));
                neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                neg_r <= dividend[WIDTH-1];
`else
                dvd <= dividend;
                dvs <= divisor;
`endif
            end
        end else if (state == CALC) begin
            prem <= step_prem;
            dvd  <= {dvd[WIDTH-2:0], step_q};
            cnt  <= cnt - CNT_W'(1);
            if (last) begin
                quotient  <= q_res;
                remainder <= r_res;
            end
        end
    end

endmodule

// File: tb/tb_sa_seq_divider.sv
// tb_sa_seq_divider: self-checking bench for sa_seq_divider (WIDTH=8).
// Build with +define+SA_DIV_SIGNED_EN to exercise the signed variant.
module tb_sa_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    // expected entry: {div_by_zero, quotient, remainder}
    logic [2*W:0] exp_q[$];

    sa_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer division from the operand values.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) begin
            return {1'b1, {W{1'b1}}, a};
        end
`ifdef SA_DIV_SIGNED_EN
        begin
            int sa;
            int sb;
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
`else
        begin
            int unsigned ua;
            int unsigned ub;
            ua = a;
            ub = b;
            q  = W'(ua / ub);
            r  = W'(ua % ub);
        end
`endif
        return {1'b0, q, r};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    initial begin : compare
        logic         rs;
        logic [2*W:0] e;
        logic [W-1:0] cur_q;
        logic [W-1:0] cur_r;
        cur_q = '0;
        cur_r = '0;
        forever begin
            @(posedge clk);
            rs = rst_n;
            @(negedge clk);
            if (!rs) begin
                exp_q.delete();
                cur_q = '0;
                cur_r = '0;
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_q", 64'(quotient), 64'(0));
                chk("rst_r", 64'(remainder), 64'(0));
                chk("rst_dbz", 64'(div_by_zero), 64'(0));
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    chk("stray_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    cur_q = e[2*W-1:W];
                    cur_r = e[W-1:0];
                    chk("sb_q", 64'(quotient), 64'(cur_q));
                    chk("sb_r", 64'(remainder), 64'(cur_r));
                    chk("sb_dbz", 64'(div_by_zero), 64'(e[2*W]));
                end
            end else begin
                chk("hold_q", 64'(quotient), 64'(cur_q));
                chk("hold_r", 64'(remainder), 64'(cur_r));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge while the DUT is ready.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Counts edges until done; busy must stay high for a real divide.
    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        while (!done && n < 4 * W) begin
            chk("busy_calc", 64'(busy), 64'(1));
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("busy_at_done", 64'(busy), 64'(0));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] lq, input logic [W-1:0] lr, input logic ldbz);
        issue(a, b);
        wait_done((b == '0) ? 0 : W);
        chk("lit_q", 64'(quotient), 64'(lq));
        chk("lit_r", 64'(remainder), 64'(lr));
        chk("lit_dbz", 64'(div_by_zero), 64'(ldbz));
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic rand_op();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom);
        b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        issue(a, b);
        wait_done((b == '0) ? 0 : W);
        @(posedge clk); #1;
        chk("rand_done_pulse", 64'(done), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // pin the model against hand-computed values
        chk("model_100_7", 64'(model(8'd100, 8'd7)), 64'({1'b0, 8'd14, 8'd2}));
        chk("model_37_0", 64'(model(8'd37, 8'd0)), 64'({1'b1, 8'hFF, 8'd37}));
        chk("model_9_3", 64'(model(8'd9, 8'd3)), 64'({1'b0, 8'd3, 8'd0}));

        // directed cases
        op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        op(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1);
        op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
`ifdef SA_DIV_SIGNED_EN
        op(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
        op(8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0);
        op(8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0);
        op(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0);
`else
        op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
`endif

        // start pulsed mid-CALC is ignored
        issue(8'd100, 8'd7);
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done(W - 2);
        chk("ignore_q", 64'(quotient), 64'(14));
        chk("ignore_r", 64'(remainder), 64'(2));
        @(posedge clk); #1;

        // start held through DONE: back-to-back accept
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd5;
        exp_q.push_back(model(8'd77, 8'd5));
        @(posedge clk); #1;
        dividend = 8'd60;
        divisor  = 8'd11;
        exp_q.push_back(model(8'd60, 8'd11));
        wait_done(W);
        chk("b2b_q1", 64'(quotient), 64'(15));
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_pulse", 64'(done), 64'(0));
        chk("b2b_busy", 64'(busy), 64'(1));
        wait_done(W);
        chk("b2b_q2", 64'(quotient), 64'(5));
        chk("b2b_r2", 64'(remainder), 64'(5));
        @(posedge clk); #1;

        // reset mid-operation
        issue(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_q", 64'(quotient), 64'(0));
        chk("abort_r", 64'(remainder), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            chk("no_stray_done", 64'(done), 64'(0));
        end

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            rand_op();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_seq_divider.md
Name: sa_seq_divider

Overview:
- Parametrised multi-cycle restoring divider. Successor to the single-step signed divide cell.
- Produces one quotient bit per clock over WIDTH iterations, with a start/busy/done handshake.
- Holds the result and flags divide-by-zero.
- Sits in the arithmetic datapath as the slow-division reference unit, against which the fast divider is compared.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only when ready (state IDLE or DONE).
- dividend  in  WIDTH  dividend, captured on accepted start.
- divisor  in  WIDTH  divisor, captured on accepted start.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse: result valid.
- quotient  out  WIDTH  registered quotient, held until next completion.
- remainder  out  WIDTH  registered remainder, held until next completion.
- div_by_zero  out  1  registered; set with done when the captured divisor==0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Reset mid-CALC aborts the operation; no done pulse is produced.
- States: IDLE, CALC, DONE.
  - IDLE/DONE + start, divisor!=0 -> CALC. Capture |operands| (signed build) or raw operands. Clear partial remainder. Counter = WIDTH.
  - IDLE/DONE + start, divisor==0 -> DONE. quotient = all ones, remainder = dividend, div_by_zero=1. done is high the next cycle.
  - CALC, each edge:
    - Shift {prem, dvd} left 1; trial = prem - dvs.
    - If trial >= 0: prem = trial, quotient LSB = 1. Else prem unchanged, LSB = 0.
    - Counter decrements. Leaving the counter==1 iteration -> DONE; results registered, sign-corrected.
  - DONE -> IDLE after one cycle if start is low. done=1 only while in DONE.
- Latency:
  - Start accepted at edge T0 -> done high during the cycle after edge T0+WIDTH.
  - Divide-by-zero: done high after edge T0 (1 cycle).
- Back-to-back: start asserted in DONE is accepted. The done pulse still lasts exactly one cycle.
- start while busy is ignored. Operand inputs are don't-care outside an accepted start.
- div_by_zero is cleared on the next accepted start with nonzero divisor.
- Internal datapath:
  - Partial remainder is WIDTH+1 bits (carries the sign of the trial subtraction).
  - Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| is representable.
- Outputs change only on entry to DONE (or on reset).

Optional Feature:
- Macro: SA_DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement; division runs on magnitudes.
  - quotient sign = sign(dividend) XOR sign(divisor); remainder takes the sign of the dividend (truncate toward zero).
  - Overflow -2^(WIDTH-1) / -1 wraps: quotient = -2^(WIDTH-1), remainder 0.
- Undefined: operands and results are unsigned; there is no sign correction logic.

Decomposition:
- Package sa_div_pkg:
  - state enum (IDLE, CALC, DONE).
  - localparam for the divide-by-zero quotient (all ones).
  - function abs_mag(WIDTH) for the signed build.
- One sub-module, sa_div_step: combinational single restoring iteration.
  - Inputs: prem, next dividend bit, divisor.
  - Outputs: new prem, quotient bit.
  - Instantiated once and reused every CALC cycle.

Test Plan (WIDTH=8):
- Basic divide, both builds: 100/7, start at T0 -> busy for 8 cycles, done at T0+8 cycle, q=14, r=2, div_by_zero=0.
- Sign combinations, signed build:
  - -100/7 -> q=-14, r=-2.
  - 100/-7 -> q=-14, r=2.
  - -100/-7 -> q=14, r=-2.
- Divide-by-zero: 37/0 -> done in the cycle after T0, q=8'hFF, r=37, div_by_zero=1. Follow with 9/3 -> q=3, r=0, div_by_zero=0.
- Overflow and full-width operands:
  - Signed build: -128/-1 -> q=-128, r=0.
  - Unsigned build: 255/1 -> q=255, r=0.
  - Unsigned build: 5/9 -> q=0, r=5.
- Handshake edge cases:
  - start pulsed mid-CALC with new operands -> ignored; the first result is unchanged.
  - start held in DONE -> a second op is accepted back-to-back; done is a one-cycle pulse each time.
- Reset mid-operation: rst_n low at CALC cycle 4 -> next cycle busy=0, done=0, q=0, r=0, state IDLE; no stray done later.
